// File: rtl/sat_acc_arbiter.sv
// sat_acc_arbiter: two requesters share one signed saturating W-bit adder,
// each with its own accumulator. Round-robin arbitration, IDLE/EXEC/DONE FSM,
// result held with valid/ready handshake.
// Optional feature macro: SAT_ACC_OVF_CNT_EN adds per-requester 4-bit
// sticky saturation-event counters (ovf_cnt0, ovf_cnt1).
module sat_acc_arbiter #(
    parameter int W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic signed [W-1:0] data0,
    input  logic signed [W-1:0] data1,
    output logic [1:0]          gnt,
    input  logic                clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_id,
    output logic signed [W-1:0] out_sum,
    output logic                out_sat
`ifdef SAT_ACC_OVF_CNT_EN
    ,
    output logic [3:0]          ovf_cnt0,
    output logic [3:0]          ovf_cnt1
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    // Clamp a W+1 bit sum to W bits: overflow shows up as the two top bits
    // disagreeing, and the top bit then gives the true sign.
    function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] x);
        if (x[W] != x[W-1])
            return x[W] ? MIN_V : MAX_V;
        else
            return x[W-1:0];
    endfunction

    function automatic logic is_sat(input logic signed [W:0] x);
        return x[W] ^ x[W-1];
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic                  r_id;      // requester being served
    logic signed [W-1:0]   r_opd;     // latched operand of that requester
    logic                  r_prio;    // requester that wins a tie
    logic signed [W-1:0]   r_acc0;
    logic signed [W-1:0]   r_acc1;

    logic                  w_take;
    logic                  w_win;
    logic signed [W-1:0]   w_acc_sel;
    logic signed [W:0]     w_a_x;
    logic signed [W:0]     w_b_x;
    logic signed [W:0]     w_sum_x;
    logic signed [W-1:0]   w_sum_sat;
    logic                  w_ovf;

    // A new operation starts only from IDLE; clr takes precedence over req.
    assign w_take = (r_state == S_IDLE) && !clr && (req != 2'b00);

    // Single requester wins outright; on a tie the priority pointer decides.
    assign w_win = (req == 2'b11) ? r_prio : req[1];

    // Shared adder, evaluated at W+1 bits so overflow is never lost.
    assign w_acc_sel = r_id ? r_acc1 : r_acc0;
    assign w_a_x     = {w_acc_sel[W-1], w_acc_sel};
    assign w_b_x     = {r_opd[W-1], r_opd};
    assign w_sum_x   = w_a_x + w_b_x;
    assign w_sum_sat = sat_w(w_sum_x);
    assign w_ovf     = is_sat(w_sum_x);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_take) w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: grant pulses for the single EXEC cycle, valid during DONE.
    always_comb begin
        gnt       = 2'b00;
        out_valid = 1'b0;
        if (r_state == S_EXEC)
            gnt = r_id ? 2'b10 : 2'b01;
        if (r_state == S_DONE)
            out_valid = 1'b1;
    end

    // Datapath: operand capture, accumulator update, result registers, pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id    <= 1'b0;
            r_opd   <= '0;
            r_prio  <= 1'b0;
            r_acc0  <= '0;
            r_acc1  <= '0;
            out_id  <= 1'b0;
            out_sum <= '0;
            out_sat <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        r_acc0 <= '0;
                        r_acc1 <= '0;
                    end else if (w_take) begin
                        r_id  <= w_win;
                        r_opd <= w_win ? data1 : data0;
                    end
                end
                S_EXEC: begin
                    if (r_id)
                        r_acc1 <= w_sum_sat;
                    else
                        r_acc0 <= w_sum_sat;
                    out_id  <= r_id;
                    out_sum <= w_sum_sat;
                    out_sat <= w_ovf;
                end
                S_DONE: begin
                    if (out_ready)
                        r_prio <= ~r_id;
                end
                default: ;
            endcase
        end
    end

`ifdef SAT_ACC_OVF_CNT_EN
    logic [3:0] r_cnt0;
    logic [3:0] r_cnt1;

    assign ovf_cnt0 = r_cnt0;
    assign ovf_cnt1 = r_cnt1;

    // Sticky saturation-event counters, cleared with the accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= 4'd0;
            r_cnt1 <= 4'd0;
        end else if ((r_state == S_IDLE) && clr) begin
            r_cnt0 <= 4'd0;
            r_cnt1 <= 4'd0;
        end else if ((r_state == S_EXEC) && w_ovf) begin
            if (!r_id && (r_cnt0 != 4'hF))
                r_cnt0 <= r_cnt0 + 4'd1;
            if (r_id && (r_cnt1 != 4'hF))
                r_cnt1 <= r_cnt1 + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sat_acc_arbiter.sv
// Directed testbench for sat_acc_arbiter (W=4) with a result scoreboard.
module tb_sat_acc_arbiter;

    localparam int W = 4;

    logic                clk;
    logic                rst_n;
    logic [1:0]          req;
    logic signed [W-1:0] data0;
    logic signed [W-1:0] data1;
    logic [1:0]          gnt;
    logic                clr;
    logic                out_valid;
    logic                out_ready;
    logic                out_id;
    logic signed [W-1:0] out_sum;
    logic                out_sat;
`ifdef SAT_ACC_OVF_CNT_EN
    logic [3:0]          ovf_cnt0;
    logic [3:0]          ovf_cnt1;
`endif

    sat_acc_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .gnt       (gnt),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_sum   (out_sum),
        .out_sat   (out_sat)
`ifdef SAT_ACC_OVF_CNT_EN
        ,
        .ovf_cnt0  (ovf_cnt0),
        .ovf_cnt1  (ovf_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic                id;
        logic signed [W-1:0] sum;
        logic                sat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got id=%0d sum=%0d sat=%0d expected no result",
                         out_id, out_sum, out_sat);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_id",  int'(out_id),  int'(e.id));
                chk("sb_sum", int'(out_sum), int'(e.sum));
                chk("sb_sat", int'(out_sat), int'(e.sat));
            end
        end
    end

    task automatic push_exp(input bit eid, input int esum, input bit esat);
        exp_t e;
        e.id  = eid;
        e.sum = esum[W-1:0];
        e.sat = esat;
        q.push_back(e);
    endtask

    // One full operation starting in IDLE: sample, grant, result, accept.
    task automatic do_op(input logic [1:0] r, input int d0, input int d1, input bit hold,
                         input bit eid, input int esum, input bit esat);
        req       = r;
        data0     = d0[W-1:0];
        data1     = d1[W-1:0];
        out_ready = 1'b1;
        push_exp(eid, esum, esat);
        @(posedge clk); #1;
        chk("gnt", int'(gnt), eid ? 2 : 1);
        if (!hold) req = 2'b00;
        @(posedge clk); #1;
        chk("valid_latency", int'(out_valid), 1);
        chk("gnt_in_done", int'(gnt), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; data0 = '0; data1 = '0; clr = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_gnt",   int'(gnt), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_id",    int'(out_id), 0);
        chk("rst_sum",   int'(out_sum), 0);
        chk("rst_sat",   int'(out_sat), 0);
        rst_n = 1'b1;

        // Basic add, then positive and negative clamping on requester 0.
        do_op(2'b01,  3, 0, 0, 0,  3, 0);
        do_op(2'b01,  6, 0, 0, 0,  7, 1);
        do_op(2'b01, -8, 0, 0, 0, -1, 0);
        do_op(2'b01, -8, 0, 0, 0, -8, 1);

        // clr together with req in IDLE: no grant, accumulators cleared.
        clr = 1'b1; req = 2'b01; data0 = 4'sd5;
        @(posedge clk); #1;
        chk("clr_no_gnt", int'(gnt), 0);
        clr = 1'b0; req = 2'b00;
        @(posedge clk); #1;
        chk("clr_no_gnt2", int'(gnt), 0);

        // Requester 1 alone, so the tie pointer then favours requester 0.
        do_op(2'b10, 0, 2, 0, 1, 2, 0);

        // Both requesting continuously: alternate 0,1,0,1, accumulators independent.
        do_op(2'b11, 1, 3, 1, 0, 1, 0);
        do_op(2'b11, 1, 3, 1, 1, 5, 0);
        do_op(2'b11, 1, 3, 1, 0, 2, 0);
        do_op(2'b11, 1, 3, 0, 1, 7, 1);

        // Back-pressure: result held stable for 4 cycles with no new grant.
        req = 2'b01; data0 = 4'sd1; out_ready = 1'b1;
        push_exp(0, 3, 0);
        @(posedge clk); #1;
        chk("bp_gnt", int'(gnt), 1);
        req = 2'b00; out_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_sum",   int'(out_sum), 3);
            chk("bp_id",    int'(out_id), 0);
            chk("bp_sat",   int'(out_sat), 0);
            chk("bp_gnt0",  int'(gnt), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("bp_valid_hold", int'(out_valid), 1);
        @(posedge clk); #1;
        chk("bp_back_idle", int'(out_valid), 0);

        // clr during EXEC is ignored; accumulators keep their values.
        req = 2'b01; data0 = 4'sd1;
        push_exp(0, 4, 0);
        @(posedge clk); #1;
        chk("clrx_gnt", int'(gnt), 1);
        clr = 1'b1; req = 2'b00;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clrx_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        do_op(2'b01, 1, 0, 0, 0, 5, 0);
        do_op(2'b10, 0, -8, 0, 1, -1, 0);

        // Reset in the middle of an operation: outputs drop at once, op discarded.
        req = 2'b01; data0 = 4'sd2;
        @(posedge clk); #1;
        chk("mid_gnt", int'(gnt), 1);
        req = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",   int'(gnt), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_id",    int'(out_id), 0);
        chk("mid_rst_sum",   int'(out_sum), 0);
        chk("mid_rst_sat",   int'(out_sat), 0);
        @(posedge clk); #1;
        chk("mid_rst_valid2", int'(out_valid), 0);
        rst_n = 1'b1;
        do_op(2'b01, -3, 0, 0, 0, -3, 0);

`ifdef SAT_ACC_OVF_CNT_EN
        // 20 clamped adds saturate the counter at 15.
        do_op(2'b01, 7, 0, 0, 0, 4, 0);
        for (int i = 0; i < 20; i++)
            do_op(2'b01, 7, 0, 0, 0, 7, 1);
        chk("ovf_cnt0_sticky", int'(ovf_cnt0), 15);
        chk("ovf_cnt1_idle",   int'(ovf_cnt1), 0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("ovf_cnt0_clr", int'(ovf_cnt0), 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sat_acc_arbiter.md
SAT_ACC_ARBITER -- requirements
Module: sat_acc_arbiter

Interface
REQ-001 Parameter W, default 4: signed operand/accumulator width, two's complement; legal range W >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  2  per-requester request; bit i belongs to requester i.
REQ-005 data0, data1  input  W each  signed operand of requester 0 / 1; held stable while the matching req bit is high.
REQ-006 gnt  output  2  one-hot grant pulse, one cycle wide.
REQ-007 clr  input  1  synchronous clear of both accumulators.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_id  output  1  requester that owns the result.
REQ-011 out_sum  output  W  new accumulator value, signed.
REQ-012 out_sat  output  1  result was clamped.

Function
REQ-013 Block SHALL hold two signed accumulators acc0, acc1 and share one signed saturating W-bit adder between the requesters.
REQ-014 The FSM SHALL have states IDLE, EXEC and DONE.
REQ-015 IDLE: with clr low and req != 0, latch the winner id and its operand, assert gnt[id] in the next cycle, and move to EXEC.
REQ-016 Arbitration SHALL be round-robin: a single req bit wins; if both are set, the requester not served last wins; after reset, requester 0 has priority.
REQ-017 EXEC: sum = acc[id] + operand computed at W+1 bits; result > 2^(W-1)-1 clamps to 2^(W-1)-1 (7 at W=4); result < -2^(W-1) clamps to -2^(W-1) (-8); acc[id] takes the clamped value; move to DONE.
REQ-018 out_sat SHALL be 1 exactly when clamping occurred.
REQ-019 DONE: out_valid=1 with out_id, out_sum and out_sat stable until the cycle in which out_ready=1; that cycle returns to IDLE and updates the last-served pointer.
REQ-020 Latency: req sampled in IDLE at cycle N -> gnt at N+1 -> out_valid first high at N+2.
REQ-021 Throughput SHALL be at most one operation per 3 cycles; no new grant while in EXEC or DONE.
REQ-022 clr in IDLE SHALL zero acc0 and acc1 and suppress a grant that cycle (clr has priority over req); clr in EXEC or DONE SHALL be ignored.
REQ-023 gnt, out_id, out_sum and out_sat outside DONE: gnt=0 except its pulse; out_* hold their last values.
REQ-024 Dropping req before gnt SHALL withdraw the request; req held after gnt is treated as a new request.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, acc0=acc1=0, gnt=0, out_valid=0, out_id=0, out_sum=0, out_sat=0, priority pointer to requester 0.
REQ-026 Reset in the middle of an operation SHALL discard that operation with no accumulator write.
REQ-027 First grant SHALL be possible on the first rising edge after rst_n is released.

Configuration
REQ-028 Macro SAT_ACC_OVF_CNT_EN: when defined, add outputs ovf_cnt0 and ovf_cnt1 (4 bits each), each counting out_sat events of its requester.
REQ-029 Each counter increments in the EXEC cycle, sticks at 15, and is zeroed by reset and by clr in IDLE.
REQ-030 When SAT_ACC_OVF_CNT_EN is undefined, these ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset, then req=01, data0=3 -> gnt=01 one cycle later; out_valid two cycles after sampling, out_id=0, out_sum=3, out_sat=0.
REQ-032 acc0=3, then requester 0 presents 6 -> out_sum=7, out_sat=1; then -8 twice -> out_sum=-1, then -8 with out_sat=1.
REQ-033 req=11 held continuously with out_ready=1 -> grants alternate 01,10,01,10; acc1 independent of acc0.
REQ-034 out_ready low for 4 cycles in DONE -> out_valid and out_* stable, no gnt; release -> IDLE next cycle.
REQ-035 clr and req=01 together in IDLE -> no gnt, acc0=acc1=0; clr asserted during EXEC -> ignored, write completes.
REQ-036 rst_n low during EXEC -> outputs at reset values immediately, accumulator unchanged (0); with SAT_ACC_OVF_CNT_EN, 20 clamped adds -> ovf_cnt0=15.
